// File: rtl/main_core_serial_cmd_pkg.sv
// Shared types, widths and helpers for the main-core serial-command front end.
// Optional feature macro: MAIN_CORE_SERIAL_CMD_BYTESWAP_EN (enables the SWAP op).
package main_core_serial_cmd_pkg;

  localparam int unsigned WHICH_W = 3;
  localparam int unsigned SCMD_W  = 16;
  localparam int unsigned WORD_W  = 64;
  localparam int unsigned CMD_W   = WHICH_W + SCMD_W;

  // Serial-command payload layout: {len, addr}
  localparam int unsigned LEN_MSB  = 15;
  localparam int unsigned LEN_LSB  = 8;
  localparam int unsigned ADDR_MSB = 7;
  localparam int unsigned ADDR_LSB = 0;

  typedef enum logic [WHICH_W-1:0] {
    OP_NOP    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_XORACC = 3'd3,
    OP_CLEAR  = 3'd4,
    OP_SWAP   = 3'd5
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  // Reverse the byte order of a 64-bit word (byte 0 <-> byte 7, ...).
  function automatic logic [WORD_W-1:0] bswap64(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      r[8*i +: 8] = w[8*(7-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/main_core_serial_cmd_if.sv
// Command and data handshake bundle between the serial controller and the core.
interface main_core_serial_cmd_if;
  import main_core_serial_cmd_pkg::*;

  logic [CMD_W-1:0]  cmd;
  logic              cmd_hasAny;
  logic              cmd_consume;
  logic [WORD_W-1:0] in;
  logic              in_isReady;
  logic              in_canReceive;
  logic [WORD_W-1:0] out;
  logic              out_isReady;
  logic              out_canReceive;

  modport master (
    output cmd, cmd_hasAny, in, in_isReady, out_canReceive,
    input  cmd_consume, in_canReceive, out, out_isReady
  );

  modport slave (
    input  cmd, cmd_hasAny, in, in_isReady, out_canReceive,
    output cmd_consume, in_canReceive, out, out_isReady
  );
endinterface

// File: rtl/main_core_word_mem.sv
// 256 x 64-bit word store: combinational read, single synchronous write,
// whole-array clear on reset.
module main_core_word_mem
  import main_core_serial_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        addr,
  output logic [WORD_W-1:0] rdata,
  input  logic              we,
  input  logic [WORD_W-1:0] wdata
);

  logic [WORD_W-1:0] mem [256];

  assign rdata = mem[addr];

  // Reset wipes every word; otherwise write the addressed word when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/main_core_serial_cmd.sv
// Serial-command front end of the main core: takes one command at a time and
// streams words between the in/out ports and the word memory, or edits it in place.
// Optional feature macro: MAIN_CORE_SERIAL_CMD_BYTESWAP_EN (SWAP op; else which=5 is a NOP).
module main_core_serial_cmd
  import main_core_serial_cmd_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  main_core_serial_cmd_if.slave bus
);

  state_e            state, state_nxt;
  op_e               op, which;
  logic [7:0]        ptr, len, addr;
  logic [8:0]        cnt;
  logic              cmd_runs, step, we;
  logic [WORD_W-1:0] rdata, wdata;

  assign which = op_e'(bus.cmd[CMD_W-1 -: WHICH_W]);
  assign len   = bus.cmd[LEN_MSB:LEN_LSB];
  assign addr  = bus.cmd[ADDR_MSB:ADDR_LSB];

  main_core_word_mem u_mem (
    .clk   (clk),
    .rst   (rst),
    .addr  (ptr),
    .rdata (rdata),
    .we    (we),
    .wdata (wdata)
  );

  // Decide whether the presented command needs a RUN phase at all.
  always_comb begin
    cmd_runs = 1'b0;
    case (which)
      OP_LOAD, OP_STORE, OP_XORACC, OP_CLEAR: cmd_runs = (len != 8'd0);
`ifdef MAIN_CORE_SERIAL_CMD_BYTESWAP_EN
      OP_SWAP:                                cmd_runs = (len != 8'd0);
`endif
      default:                                cmd_runs = 1'b0;
    endcase
  end

  // Handshake outputs, per-word step/write decode and next state.
  always_comb begin
    bus.cmd_consume   = (state == ST_IDLE) && bus.cmd_hasAny;
    bus.in_canReceive = (state == ST_RUN) && (op == OP_LOAD || op == OP_XORACC);
    bus.out_isReady   = (state == ST_RUN) && (op == OP_STORE);
    bus.out           = bus.out_isReady ? rdata : '0;
    step      = 1'b0;
    wdata     = '0;
    state_nxt = state;

    if (state == ST_RUN) begin
      case (op)
        OP_LOAD: begin
          step  = bus.in_isReady;
          wdata = bus.in;
        end
        OP_XORACC: begin
          step  = bus.in_isReady;
          wdata = rdata ^ bus.in;
        end
        OP_STORE: step = bus.out_canReceive;
        OP_CLEAR: step = 1'b1;
`ifdef MAIN_CORE_SERIAL_CMD_BYTESWAP_EN
        OP_SWAP: begin
          step  = 1'b1;
          wdata = bswap64(rdata);
        end
`endif
        default: step = 1'b0;
      endcase
    end

    we = step && (op != OP_STORE);

    case (state)
      ST_IDLE: if (bus.cmd_consume && cmd_runs) state_nxt = ST_RUN;
      ST_RUN:  if (step && cnt == 9'd1) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch on consume; pointer/count advance on every processed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      op    <= OP_NOP;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (bus.cmd_consume) begin
        op  <= which;
        ptr <= addr;
        cnt <= {1'b0, len};
      end else if (step) begin
        ptr <= ptr + 8'd1;
        cnt <= cnt - 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_main_core_serial_cmd.sv
// Scoreboard bench for main_core_serial_cmd: directed scenarios plus random
// commands against an array-based memory model.
module tb_main_core_serial_cmd;
  import main_core_serial_cmd_pkg::*;

`ifdef MAIN_CORE_SERIAL_CMD_BYTESWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  main_core_serial_cmd_if bus ();

  main_core_serial_cmd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] model [256];
  logic [63:0] sbq [$];
  logic [63:0] wq  [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitor: every accepted out word is compared with the scoreboard head.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_isReady && bus.out_canReceive) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got %h expected no word", bus.out);
        end else begin
          chk("out_word", bus.out, sbq.pop_front());
        end
      end else if (!bus.out_isReady) begin
        chk("out_idle_zero", bus.out, 64'h0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_hasAny = 1'b0;
    bus.in_isReady = 1'b0;
    bus.out_canReceive = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 64'h0;
    sbq.delete();
  endtask

  function automatic bit runs(input logic [2:0] w, input logic [7:0] len);
    return (len != 8'd0) && ((w >= 3'd1 && w <= 3'd4) || (SWAP_EN && w == 3'd5));
  endfunction

  task automatic issue(input logic [2:0] which, input logic [7:0] len, input logic [7:0] addr);
    bus.cmd = {which, len, addr};
    bus.cmd_hasAny = 1'b1;
    @(negedge clk);
    chk("cmd_consume", {63'h0, bus.cmd_consume}, 64'h1);
    tick();
    bus.cmd = 19'($urandom);
    bus.cmd_hasAny = 1'b0;
  endtask

  // Push wq[0..n-1] through the input port; xo selects XOR accumulate.
  task automatic send_words(input logic [7:0] addr, input int n, input bit xo, input bit final_chk);
    for (int i = 0; i < n; i++) begin
      bit done;
      logic [7:0] a;
      done = 1'b0;
      a = addr + 8'(i);
      bus.in = wq[i];
      while (!done) begin
        bus.in_isReady = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        chk("in_canReceive_run", {63'h0, bus.in_canReceive}, 64'h1);
        if (!bus.in_canReceive) done = 1'b1;
        else if (bus.in_isReady) begin
          done = 1'b1;
          model[a] = xo ? (model[a] ^ wq[i]) : wq[i];
        end
        tick();
      end
    end
    if (final_chk) begin
      bus.in_isReady = 1'b1;
      @(negedge clk);
      chk("in_canReceive_done", {63'h0, bus.in_canReceive}, 64'h0);
      tick();
    end
    bus.in_isReady = 1'b0;
  endtask

  task automatic store(input logic [7:0] addr, input logic [7:0] len);
    int guard;
    guard = 0;
    for (int i = 0; i < int'(len); i++) sbq.push_back(model[addr + 8'(i)]);
    while (sbq.size() != 0 && guard < 300) begin
      bus.out_canReceive = ($urandom_range(0, 2) != 0);
      tick();
      guard++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL store_timeout: got %0d words pending expected 0", sbq.size());
      sbq.delete();
    end
    bus.out_canReceive = 1'b1;
    @(negedge clk);
    chk("out_isReady_done", {63'h0, bus.out_isReady}, 64'h0);
    tick();
    bus.out_canReceive = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] which, input logic [7:0] len, input logic [7:0] addr);
    issue(which, len, addr);
    if (!runs(which, len)) begin
      bus.in_isReady = 1'b1;
      bus.out_canReceive = 1'b1;
      @(negedge clk);
      chk("nop_in_canReceive", {63'h0, bus.in_canReceive}, 64'h0);
      chk("nop_out_isReady", {63'h0, bus.out_isReady}, 64'h0);
      tick();
      bus.in_isReady = 1'b0;
      bus.out_canReceive = 1'b0;
    end else begin
      case (which)
        3'd1: send_words(addr, int'(len), 1'b0, 1'b1);
        3'd3: send_words(addr, int'(len), 1'b1, 1'b1);
        3'd2: store(addr, len);
        3'd4: begin
          for (int i = 0; i < int'(len); i++) model[addr + 8'(i)] = 64'h0;
          repeat (int'(len)) tick();
        end
        default: begin
          for (int i = 0; i < int'(len); i++) begin
            logic [63:0] v;
            v = model[addr + 8'(i)];
            model[addr + 8'(i)] = {<<8{v}};
          end
          repeat (int'(len)) tick();
        end
      endcase
    end
  endtask

  initial begin
    bus.cmd = '0;
    bus.cmd_hasAny = 1'b0;
    bus.in = '0;
    bus.in_isReady = 1'b0;
    bus.out_canReceive = 1'b0;
    do_reset();

    @(negedge clk);
    chk("rst_cmd_consume", {63'h0, bus.cmd_consume}, 64'h0);
    chk("rst_in_canReceive", {63'h0, bus.in_canReceive}, 64'h0);
    chk("rst_out_isReady", {63'h0, bus.out_isReady}, 64'h0);
    chk("rst_out", bus.out, 64'h0);
    tick();
    bus.out_canReceive = 1'b1;
    bus.in_isReady = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_out_isReady", {63'h0, bus.out_isReady}, 64'h0);
      tick();
    end
    bus.out_canReceive = 1'b0;
    bus.in_isReady = 1'b0;

    run_cmd(3'd2, 8'd2, 8'd0);

    wq.delete();
    wq.push_back(64'h0123456789ABCDEF);
    wq.push_back(64'h1);
    wq.push_back(64'hFFFF0000FFFF0000);
    run_cmd(3'd1, 8'd3, 8'd8);
    run_cmd(3'd2, 8'd3, 8'd8);

    wq.delete();
    wq.push_back(64'hA);
    wq.push_back(64'hB);
    run_cmd(3'd1, 8'd2, 8'd255);
    run_cmd(3'd2, 8'd1, 8'd0);

    wq.delete();
    wq.push_back(64'h0123456789ABCDEF);
    run_cmd(3'd3, 8'd1, 8'd8);
    run_cmd(3'd2, 8'd1, 8'd8);
    run_cmd(3'd4, 8'd3, 8'd8);
    run_cmd(3'd2, 8'd3, 8'd8);

    run_cmd(3'd1, 8'd1, 8'd4);
    run_cmd(3'd5, 8'd1, 8'd4);
    run_cmd(3'd2, 8'd1, 8'd4);

    run_cmd(3'd0, 8'd5, 8'd3);
    run_cmd(3'd1, 8'd0, 8'd3);
    run_cmd(3'd6, 8'd2, 8'd0);
    run_cmd(3'd7, 8'd2, 8'd0);

    // Abort a LOAD halfway through with a reset pulse.
    wq.delete();
    repeat (4) wq.push_back({$urandom, $urandom});
    issue(3'd1, 8'd4, 8'd16);
    send_words(8'd16, 2, 1'b0, 1'b0);
    bus.in_isReady = 1'b1;
    do_reset();
    bus.in_isReady = 1'b1;
    @(negedge clk);
    chk("abort_in_canReceive", {63'h0, bus.in_canReceive}, 64'h0);
    tick();
    bus.in_isReady = 1'b0;
    run_cmd(3'd2, 8'd4, 8'd16);

    // Random command mix over a small address window.
    for (int n = 0; n < 60; n++) begin
      logic [2:0] w;
      logic [7:0] l, a;
      w = 3'($urandom_range(0, 7));
      l = 8'($urandom_range(0, 5));
      a = 8'($urandom_range(250, 270));
      wq.delete();
      for (int k = 0; k < int'(l); k++) wq.push_back({$urandom, $urandom});
      run_cmd(w, l, a);
      if ($urandom_range(0, 2) == 0) run_cmd(3'd2, 8'($urandom_range(1, 6)), 8'($urandom_range(250, 270)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
